// File: rtl/f2p_pkg.sv
// Shared types, constants and helpers for the float-to-posit converter.
// The leading-zero counter exists only when F2P_SUBNORM_EN is defined.
package f2p_pkg;

    localparam int unsigned XW = 13;   // signed unbiased exponent, covers FE up to 11
    localparam int unsigned FW = 52;   // fraction field, left-aligned

    localparam int unsigned FLAG_NAR     = 2;
    localparam int unsigned FLAG_SAT     = 1;
    localparam int unsigned FLAG_INEXACT = 0;

    typedef enum logic [1:0] {
        CLS_NORM  = 2'd0,
        CLS_ZERO  = 2'd1,
        CLS_NAR   = 2'd2,
        CLS_FLUSH = 2'd3
    } f2p_cls_e;

    typedef struct packed {
        logic                 sign;
        f2p_cls_e             cls;
        logic signed [XW-1:0] x;
        logic [FW-1:0]        f;
    } f2p_s1_t;

    function automatic int unsigned f2p_fs(input int unsigned fn, input int unsigned fe);
        return fn - fe - 1;
    endfunction

    function automatic int f2p_bias(input int unsigned fe);
        return (1 << (fe - 1)) - 1;
    endfunction

    function automatic logic [31:0] posit_nar(input int unsigned n);
        return 32'h1 << (n - 1);
    endfunction

    function automatic logic [31:0] posit_maxpos(input int unsigned n);
        return posit_nar(n) - 32'h1;
    endfunction

    function automatic logic [31:0] posit_minpos(input int unsigned n);
        return (n > 0) ? 32'h1 : 32'h0;
    endfunction

`ifdef F2P_SUBNORM_EN
    function automatic int f2p_lzc(input logic [FW-1:0] v);
        int   n;
        logic found;
        n     = 0;
        found = 1'b0;
        for (int i = int'(FW) - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 1;
            end
        end
        return n;
    endfunction
`endif

endpackage

// File: rtl/posit_round_pack.sv
// Final posit assembly: round-to-nearest-even, special/saturation select, sign negation.
module posit_round_pack
    import f2p_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         sign,
    input  f2p_cls_e     cls,
    input  logic         sat_hi,
    input  logic         sat_lo,
    input  logic [N-2:0] body,
    input  logic         guard,
    input  logic         sticky,
    output logic [N-1:0] data_c,
    output logic [2:0]   flags_c
);
    localparam logic [N-1:0] NAR    = N'(posit_nar(N));
    localparam logic [N-1:0] MAXPOS = N'(posit_maxpos(N));
    localparam logic [N-1:0] MINPOS = N'(posit_minpos(N));

    logic [N-2:0] rnd;
    logic [N-1:0] mag;

    always_comb begin
        rnd     = body + (N-1)'(guard & (body[0] | sticky));
        mag     = {1'b0, rnd};
        data_c  = '0;
        flags_c = '0;
        case (cls)
            CLS_NAR: begin
                data_c            = NAR;
                flags_c[FLAG_NAR] = 1'b1;
            end
            CLS_FLUSH: flags_c[FLAG_INEXACT] = 1'b1;
            CLS_NORM: begin
                if (sat_hi || sat_lo) begin
                    mag                   = sat_hi ? MAXPOS : MINPOS;
                    flags_c[FLAG_SAT]     = 1'b1;
                    flags_c[FLAG_INEXACT] = 1'b1;
                end else begin
                    flags_c[FLAG_INEXACT] = guard | sticky;
                end
                data_c = sign ? -mag : mag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/f2p_conv_pipe.sv
// 3-stage stallable IEEE-754 float to posit converter with valid/ready handshaking.
// Define F2P_SUBNORM_EN to normalise subnormal inputs instead of flushing them to zero.
module f2p_conv_pipe
    import f2p_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned ES = 1,
    parameter int unsigned FN = 32,
    parameter int unsigned FE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FN-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [2:0]    out_flags
);
    localparam int unsigned FS      = f2p_fs(FN, FE);
    localparam int          BIAS    = f2p_bias(FE);
    localparam int unsigned TLW     = ES + FW;
    localparam int unsigned TW      = N - 1 + TLW;
    localparam int          SAT_LIM = int'((2 ** ES) * (N - 2));

    logic          en1, en2, en3;
    logic          v1, v2;
    f2p_s1_t       s1_d, s1_q;
    logic [FE-1:0] e_c;
    logic [FS-1:0] f_c;
    logic [FW-1:0] f52_c;

    logic          sign2, sat_hi2, sat_lo2, guard2, sticky2;
    f2p_cls_e      cls2;
    logic [N-2:0]  body2;
    logic          sat_hi_c, sat_lo_c, guard_c, sticky_c;
    logic [N-2:0]  body_c;
    logic [N-2:0]  rbits;
    logic [TLW-1:0] tail;
    logic [TW-1:0] full;
    int            x_s, k_i, rlen_i;
    logic [N-1:0]  data_c;
    logic [2:0]    flags_c;

    // Each stage loads when its successor is empty or draining
    assign en3      = !out_valid || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;

    assign e_c   = in_data[FN-2 -: FE];
    assign f_c   = in_data[FS-1:0];
    assign f52_c = FW'({f_c, {FW{1'b0}}} >> FS);

`ifdef F2P_SUBNORM_EN
    int lz_c;
    assign lz_c = f2p_lzc(f52_c);
`endif

    // S1: classify and unbias the exponent
    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_data[FN-1];
        s1_d.cls  = CLS_NORM;
        s1_d.x    = XW'(int'(e_c) - BIAS);
        s1_d.f    = f52_c;
        if (e_c == '1) begin
            s1_d.cls = CLS_NAR;
        end else if (e_c == '0) begin
            if (f_c == '0) begin
                s1_d.cls = CLS_ZERO;
            end else begin
`ifdef F2P_SUBNORM_EN
                s1_d.x = XW'(1 - BIAS - (lz_c + 1));
                s1_d.f = f52_c << (lz_c + 1);
`else
                s1_d.cls = CLS_FLUSH;
`endif
            end
        end
    end

    // S2: saturation detect, regime construction and body alignment
    always_comb begin
        x_s      = int'($signed(s1_q.x));
        sat_hi_c = (s1_q.cls == CLS_NORM) && (x_s >= SAT_LIM);
        sat_lo_c = (s1_q.cls == CLS_NORM) && (x_s <= -SAT_LIM);
        k_i      = (sat_hi_c || sat_lo_c) ? 0 : (x_s >>> ES);
        if (k_i >= 0) begin
            rbits  = ~({(N-1){1'b1}} >> (k_i + 1));
            rlen_i = k_i + 2;
        end else begin
            rbits  = {1'b1, {(N-2){1'b0}}} >> (-k_i);
            rlen_i = 1 - k_i;
        end
        tail     = TLW'({s1_q.x, s1_q.f});
        full     = {rbits, TLW'(0)} | (TW'(tail) << (N - 1 - rlen_i));
        body_c   = full[TW-1 -: N-1];
        guard_c  = full[TW-N];
        sticky_c = |full[TW-N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            s1_q <= '0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) s1_q <= s1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            sign2   <= 1'b0;
            cls2    <= CLS_ZERO;
            sat_hi2 <= 1'b0;
            sat_lo2 <= 1'b0;
            body2   <= '0;
            guard2  <= 1'b0;
            sticky2 <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                sign2   <= s1_q.sign;
                cls2    <= s1_q.cls;
                sat_hi2 <= sat_hi_c;
                sat_lo2 <= sat_lo_c;
                body2   <= body_c;
                guard2  <= guard_c;
                sticky2 <= sticky_c;
            end
        end
    end

    posit_round_pack #(.N(N)) u_pack (
        .sign    (sign2),
        .cls     (cls2),
        .sat_hi  (sat_hi2),
        .sat_lo  (sat_lo2),
        .body    (body2),
        .guard   (guard2),
        .sticky  (sticky2),
        .data_c  (data_c),
        .flags_c (flags_c)
    );

    // S3: output register holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
        end else if (en3) begin
            out_valid <= v2;
            if (v2) begin
                out_data  <= data_c;
                out_flags <= flags_c;
            end
        end
    end

endmodule

// File: tb/tb_f2p_conv_pipe.sv
// Bench for f2p_conv_pipe (N=16, ES=1, FN=32, FE=8): directed cases plus random streams
// checked against a bit-list posit encoder. Honours F2P_SUBNORM_EN like the design.
module tb_f2p_conv_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_flags;

    int tests = 0;
    int fails = 0;
    logic [18:0] exp_q[$];

    f2p_conv_pipe #(.N(16), .ES(1), .FN(32), .FE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: list regime/exponent/fraction bits, keep 15, round on the rest
    function automatic logic [18:0] model(input logic [31:0] w);
        logic        s;
        int          e, x, k, nf;
        logic [22:0] f;
        bit          q[$];
        logic [14:0] body;
        bit          g, st;
        logic [15:0] mag, d;
        logic [2:0]  fl;
        s  = w[31];
        e  = int'(w[30:23]);
        f  = w[22:0];
        nf = 23;
        if (e == 255) return {16'h8000, 3'b100};
        if (e == 0 && f == 0) return {16'h0000, 3'b000};
        if (e == 0) begin
`ifdef F2P_SUBNORM_EN
            int p;
            p = 22;
            while (f[p] == 1'b0) p--;
            x  = -126 - (23 - p);
            nf = p;
`else
            return {16'h0000, 3'b001};
`endif
        end else begin
            x = e - 127;
        end
        if (x >= 28) begin
            mag = 16'h7FFF;
            fl  = 3'b011;
        end else if (x <= -28) begin
            mag = 16'h0001;
            fl  = 3'b011;
        end else begin
            k = x >>> 1;
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            q.push_back(bit'(x & 1));
            for (int i = nf - 1; i >= 0; i--) q.push_back(f[i]);
            body = '0;
            for (int i = 0; i < 15; i++) body = {body[13:0], q.pop_front()};
            g  = (q.size() > 0) ? q.pop_front() : 1'b0;
            st = 1'b0;
            foreach (q[i]) st = st | q[i];
            mag = {1'b0, body} + 16'(g & (body[0] | st));
            fl  = {2'b00, g | st};
        end
        d = s ? (~mag + 16'd1) : mag;
        return {d, fl};
    endfunction

    function automatic logic [31:0] gen_word();
        int   r;
        logic sg;
        r  = int'($urandom_range(0, 15));
        sg = 1'($urandom);
        case (r)
            0: return $urandom;
            1: return {sg, 8'hFF, 23'($urandom)};
            2: return {sg, 31'h0};
            3: return {sg, 8'h00, 23'($urandom)};
            4: return {sg, 8'(99 + 55 * $urandom_range(0, 1) + $urandom_range(0, 1)), 23'($urandom)};
            5: return {sg, 8'($urandom_range(96, 158)), 12'($urandom), 11'h400};
            default: return {sg, 8'($urandom_range(96, 158)), 23'($urandom)};
        endcase
    endfunction

    // Single word into an idle pipe, out_ready high; checks exact 3-cycle latency
    task automatic send_check(input string tag, input logic [31:0] w,
                              input logic [15:0] ed, input logic [2:0] ef);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(ed));
        chk({tag, "_flags"}, 32'(out_flags), 32'(ef));
    endtask

    task automatic stream(input string tag, input int nwords, input bit stall_mode);
        int          sent, got, cyc, stall_left;
        bit          stall_done, prev_stall;
        logic [15:0] held_d;
        logic [2:0]  held_f;
        logic [31:0] cur;
        logic [18:0] e;
        sent = 0; got = 0; cyc = 0; stall_left = 0;
        stall_done = 1'b0; prev_stall = 1'b0;
        held_d = '0; held_f = '0;
        exp_q.delete();
        cur = gen_word();
        while (got < nwords && cyc < 5000) begin
            in_valid = (sent < nwords) && (stall_mode || $urandom_range(0, 3) != 0);
            in_data  = cur;
            if (stall_mode) begin
                if (!stall_done && stall_left == 0 && out_valid) stall_left = 5;
                out_ready = (stall_left == 0);
            end else begin
                out_ready = ($urandom_range(0, 9) < 7);
            end
            @(negedge clk);
            if (out_valid && !out_ready) begin
                if (prev_stall) begin
                    chk({tag, "_hold_data"}, 32'(out_data), 32'(held_d));
                    chk({tag, "_hold_flags"}, 32'(out_flags), 32'(held_f));
                end
                held_d = out_data;
                held_f = out_flags;
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            if (stall_mode && stall_left == 1) begin
                chk({tag, "_full_rdy"}, 32'(in_ready), 32'd0);
                chk({tag, "_inflight"}, 32'(sent - got), 32'd3);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_extra_out"}, 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, "_data"}, 32'(out_data), 32'(e[18:3]));
                    chk({tag, "_flags"}, 32'(out_flags), 32'(e[2:0]));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data));
                sent++;
                cur = gen_word();
            end
            @(posedge clk); #1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stall_done = 1'b1;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_count"}, 32'(got), 32'(nwords));
        chk({tag, "_leftover"}, 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_idle"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send_check("one",     32'h3F800000, 16'h4000, 3'b000);
        send_check("two",     32'h40000000, 16'h5000, 3'b000);
        send_check("neg_one", 32'hBF800000, 16'hC000, 3'b000);
        send_check("tie_dn",  32'h3F800400, 16'h4000, 3'b001);
        send_check("tie_up",  32'h3F800C00, 16'h4002, 3'b001);
        send_check("inf",     32'h7F800000, 16'h8000, 3'b100);
        send_check("nan",     32'h7FC00000, 16'h8000, 3'b100);
        send_check("pzero",   32'h00000000, 16'h0000, 3'b000);
        send_check("nzero",   32'h80000000, 16'h0000, 3'b000);
        send_check("big",     32'h7149F2CA, 16'h7FFF, 3'b011);
        send_check("nbig",    32'hF149F2CA, 16'h8001, 3'b011);
        send_check("tiny",    32'h0DA24260, 16'h0001, 3'b011);
`ifdef F2P_SUBNORM_EN
        send_check("subnorm", 32'h00000001, 16'h0001, 3'b011);
`else
        send_check("subnorm", 32'h00000001, 16'h0000, 3'b001);
`endif
        @(posedge clk); #1;

        stream("bp", 8, 1'b1);
        stream("rnd", 300, 1'b0);

        // Reset with three words in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h3F800000 + 32'(i << 20);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_flags", 32'(out_flags), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send_check("post_rst", 32'h40000000, 16'h5000, 3'b000);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
